// File: rtl/run_seq_gen.sv
// Serial run-pattern generator: serializes (bit, length) commands onto
// a one-bit stream and tracks the run of identical emitted bits.
module run_seq_gen #(
  parameter int RUN_W     = 4,
  parameter int MATCH_LEN = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STEP,
  input  logic             CMD_VALID,
  input  logic             CMD_BIT,
  input  logic [RUN_W-1:0] CMD_LEN,
  output logic             CMD_READY,
  output logic             DOUT,
  output logic             DOUT_VALID,
  output logic             BUSY,
  output logic [2:0]       RUN_CNT,
  output logic             RUN_HIT
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state;
  logic             bit_r;
  logic [RUN_W-1:0] rem;
  logic             have_prev;

  assign CMD_READY = (state == IDLE) & ~RST;
  assign BUSY      = (state == EMIT);
  assign RUN_HIT   = (RUN_CNT >= 3'(MATCH_LEN));

  // Command accept, bit serialization and run-length tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      bit_r      <= 1'b0;
      rem        <= '0;
      have_prev  <= 1'b0;
      DOUT       <= 1'b0;
      DOUT_VALID <= 1'b0;
      RUN_CNT    <= 3'd0;
    end else begin
      DOUT_VALID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CMD_VALID && (CMD_LEN != '0)) begin
            bit_r <= CMD_BIT;
            rem   <= CMD_LEN;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (STEP) begin
            DOUT       <= bit_r;
            DOUT_VALID <= 1'b1;
            rem        <= rem - RUN_W'(1);
            if (rem == RUN_W'(1))
              state <= IDLE;
            if (have_prev && (bit_r == DOUT)) begin
              if (RUN_CNT != 3'd7)
                RUN_CNT <= RUN_CNT + 3'd1;
            end else begin
              RUN_CNT <= 3'd1;
            end
            have_prev <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_seq_gen.sv
// Directed bench for run_seq_gen: cycle table plus
// hand-written saturation and mid-run reset sequences.
module tb_run_seq_gen;

  logic       CLK;
  logic       RST;
  logic       STEP;
  logic       CMD_VALID;
  logic       CMD_BIT;
  logic [3:0] CMD_LEN;
  logic       CMD_READY;
  logic       DOUT;
  logic       DOUT_VALID;
  logic       BUSY;
  logic [2:0] RUN_CNT;
  logic       RUN_HIT;

  int checks;
  int failures;

  run_seq_gen #(.RUN_W(4), .MATCH_LEN(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .STEP       (STEP),
    .CMD_VALID  (CMD_VALID),
    .CMD_BIT    (CMD_BIT),
    .CMD_LEN    (CMD_LEN),
    .CMD_READY  (CMD_READY),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .BUSY       (BUSY),
    .RUN_CNT    (RUN_CNT),
    .RUN_HIT    (RUN_HIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       rst;
    logic       step;
    logic       vld;
    logic       b;
    logic [3:0] len;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  // exp packs {rdy, dout, dv, busy, cnt[2:0], hit} into the low 8 bits
  task automatic add(input int rst, input int step, input int vld,
                     input int b, input int len, input int rdy,
                     input int dout, input int dv, input int busy,
                     input int cnt, input int hit);
    vec_t v;
    v.rst  = rst[0];
    v.step = step[0];
    v.vld  = vld[0];
    v.b    = b[0];
    v.len  = len[3:0];
    v.exp  = {rdy[0], dout[0], dv[0], busy[0], cnt[2:0], hit[0]};
    tbl.push_back(v);
  endtask

  function automatic logic [7:0] obs();
    return {CMD_READY, DOUT, DOUT_VALID, BUSY, RUN_CNT, RUN_HIT};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    RST       = 1'b1;
    STEP      = 1'b0;
    CMD_VALID = 1'b0;
    CMD_BIT   = 1'b0;
    CMD_LEN   = 4'd0;

    //  rst st vl b len | rdy do dv bs cnt hit
    add(1, 1, 1, 1, 5,   0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 5,   0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 5,   0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 5,   1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0,   0, 1, 1, 1, 1, 0);
    add(0, 1, 0, 0, 0,   0, 1, 1, 1, 2, 0);
    add(0, 1, 0, 0, 0,   0, 1, 1, 1, 3, 0);
    add(0, 1, 0, 0, 0,   0, 1, 1, 1, 4, 1);
    add(0, 1, 1, 0, 3,   1, 1, 1, 0, 5, 1);
    add(0, 1, 0, 0, 0,   0, 1, 0, 1, 5, 1);
    add(0, 1, 0, 0, 0,   0, 0, 1, 1, 1, 0);
    add(0, 1, 0, 0, 0,   0, 0, 1, 1, 2, 0);
    add(0, 1, 1, 0, 2,   1, 0, 1, 0, 3, 0);
    add(0, 1, 0, 0, 0,   0, 0, 0, 1, 3, 0);
    add(0, 1, 0, 0, 0,   0, 0, 1, 1, 4, 1);
    add(0, 1, 1, 1, 4,   1, 0, 1, 0, 5, 1);
    add(0, 1, 0, 0, 0,   0, 0, 0, 1, 5, 1);
    add(0, 1, 0, 0, 0,   0, 1, 1, 1, 1, 0);
    add(0, 1, 0, 0, 0,   0, 1, 1, 1, 2, 0);
    add(0, 1, 0, 0, 0,   0, 1, 1, 1, 3, 0);
    add(0, 1, 1, 0, 1,   1, 1, 1, 0, 4, 1);
    add(0, 1, 0, 0, 0,   0, 1, 0, 1, 4, 1);
    add(0, 1, 1, 1, 0,   1, 0, 1, 0, 1, 0);
    add(0, 1, 0, 0, 0,   1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 3,   1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0,   0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0,   0, 0, 1, 1, 2, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0, 1, 2, 0);
    add(0, 1, 0, 0, 0,   0, 0, 0, 1, 2, 0);
    add(0, 0, 0, 0, 0,   0, 0, 1, 1, 3, 0);
    add(0, 1, 0, 0, 0,   0, 0, 0, 1, 3, 0);
    add(0, 0, 0, 0, 0,   1, 0, 1, 0, 4, 1);
    add(0, 0, 0, 0, 0,   1, 0, 0, 0, 4, 1);

    @(posedge CLK);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      RST       = tbl[i].rst;
      STEP      = tbl[i].step;
      CMD_VALID = tbl[i].vld;
      CMD_BIT   = tbl[i].b;
      CMD_LEN   = tbl[i].len;
      #1;
      chk($sformatf("row%0d", i), obs(), tbl[i].exp);
    end

    // saturation: cmd (1,9) after a run of zeros
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_BIT   = 1'b1;
    CMD_LEN   = 4'd9;
    STEP      = 1'b0;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    STEP      = 1'b1;
    chk("sat_busy", {7'd0, BUSY}, 8'd1);
    for (int k = 1; k <= 9; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("sat_bit%0d", k),
          {3'd0, DOUT_VALID, DOUT, RUN_CNT},
          {3'd0, 1'b1, 1'b1, 3'((k > 7) ? 7 : k)});
      chk($sformatf("sat_hit%0d", k), {7'd0, RUN_HIT},
          {7'd0, (k >= 4) ? 1'b1 : 1'b0});
    end
    chk("sat_done", {6'd0, CMD_READY, BUSY}, 8'b10);

    // mid-run reset: cmd (1,6), reset after two pulses
    @(negedge CLK);
    STEP      = 1'b0;
    CMD_VALID = 1'b1;
    CMD_BIT   = 1'b1;
    CMD_LEN   = 4'd6;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    STEP      = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("mr_pulse%0d", k),
          {4'd0, DOUT_VALID, RUN_CNT}, {4'd0, 1'b1, 3'd7});
    end
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("mr_reset", obs(), 8'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("mr_quiet%0d", k),
          {5'd0, CMD_READY, DOUT_VALID, BUSY}, 8'b100);
    end
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_BIT   = 1'b1;
    CMD_LEN   = 4'd2;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    @(posedge CLK);
    #1;
    chk("mr_bit1", obs(), {1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0});
    @(posedge CLK);
    #1;
    chk("mr_bit2", obs(), {1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0});
    @(negedge CLK);
    STEP = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_seq_gen.md
# run_seq_gen

Serial run-pattern generator: the transmit-side counterpart of the team's 4-in-a-row sequence detector. Commands of the form (bit value, run length) arrive over a valid/ready handshake. The block serializes each command onto a one-bit stream, one bit per `STEP` enable, so it can drive a detector or act as its stimulus source. It also tracks the run of identical emitted bits and flags when that run reaches `MATCH_LEN`, giving a reference output to compare against the detector's `z`.

## Interface
- `RUN_W`, 4, width of the command run-length field (max run 2^RUN_W−1 bits).
- `MATCH_LEN`, 4, run length at which `RUN_HIT` asserts; legal range 1..7.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `STEP`  in  1  advance enable; one bit is emitted per cycle `STEP`=1 while emitting.
- `CMD_VALID`  in  1  command present.
- `CMD_BIT`  in  1  bit value to emit.
- `CMD_LEN`  in  RUN_W  number of bits to emit; 0 is legal (no-op).
- `CMD_READY`  out  1  block can accept a command.
- `DOUT`  out  1  last emitted bit (held).
- `DOUT_VALID`  out  1  one-cycle pulse per emitted bit.
- `BUSY`  out  1  emitting a command.
- `RUN_CNT`  out  3  length of the current run of identical emitted bits, saturating at 7.
- `RUN_HIT`  out  1  `RUN_CNT` ≥ `MATCH_LEN`.

## Operation
- Two states: IDLE and EMIT. Registers: `bit_r`, `rem` (RUN_W bits), `have_prev`, `RUN_CNT`, `DOUT`, `DOUT_VALID`.
- `CMD_READY` = (state==IDLE) & ~`RST`, combinational. `BUSY` = (state==EMIT).
- **IDLE:**
  - Accept a command when `CMD_VALID` & `CMD_READY` at a rising edge.
  - If `CMD_LEN`≠0: `bit_r`←`CMD_BIT`, `rem`←`CMD_LEN`, go to EMIT.
  - If `CMD_LEN`=0: the command is consumed, nothing is emitted, and the block stays in IDLE.
- **EMIT, on an edge with `STEP`=1:**
  - `DOUT`←`bit_r`; `DOUT_VALID`←1; `rem`←`rem`−1.
  - If `rem` was 1, go to IDLE.
  - Run tracking:
    - If `have_prev` & (`bit_r`==`DOUT`): `RUN_CNT`←min(`RUN_CNT`+1, 7).
    - Otherwise: `RUN_CNT`←1.
    - `have_prev`←1.
- **EMIT, on an edge with `STEP`=0:** all state holds and `DOUT_VALID`←0.
- Runs span command boundaries. Consecutive commands with the same bit extend `RUN_CNT`, matching a detector that sees one continuous stream.
- `RUN_HIT` = (`RUN_CNT` ≥ `MATCH_LEN`), combinational from the register.
  - It stays high while the run continues.
  - It drops on the first emitted bit of opposite value.
- `STEP` in IDLE has no effect. `CMD_VALID` in EMIT is ignored; the upstream source must hold it.
- **`RST`=1 at any edge:**
  - state←IDLE; `rem`←0; `DOUT`←0; `DOUT_VALID`←0; `RUN_CNT`←0; `have_prev`←0.
  - Any in-flight command is discarded.
  - `RST` takes priority over `STEP` and `CMD_VALID` in the same cycle.

## Timing
- Reset values:
  - `CMD_READY` is 0 while `RST`=1 and 1 on the first cycle after reset deasserts.
  - `DOUT`, `DOUT_VALID`, `BUSY`, `RUN_CNT`, `RUN_HIT` are all 0.
- Acceptance happens at edge N. `BUSY`=1 and `CMD_READY`=0 from cycle N+1. A `STEP` in cycle N is not used for this command.
- First bit: with `STEP`=1 in cycle N+1, `DOUT` and `DOUT_VALID` are valid in cycle N+2. `RUN_CNT` and `RUN_HIT` update in the same cycle as `DOUT`.
- A command of length L with `STEP` held high emits L consecutive `DOUT_VALID` pulses. `CMD_READY` reasserts in the cycle after the last pulse's edge, i.e. in the same cycle the last bit appears.
- Maximum throughput is one command per L+1 cycles. A zero-length command occupies one accept cycle.
- `RUN_CNT` saturates at 7 and never wraps. `rem` never underflows, because EMIT is never entered with `rem`=0.

## Test plan
- **Reset:** hold `RST` for 3 cycles, with `CMD_VALID`=1 during reset → `CMD_READY`=0 and all outputs 0 during reset. After release, `CMD_READY`=1 and the command is accepted on the first edge.
- **Single run:** cmd (1,5), `STEP`=1 continuously → `DOUT`=1 with 5 `DOUT_VALID` pulses; `RUN_CNT` 1,2,3,4,5; `RUN_HIT` rises with the 4th pulse; `CMD_READY` is back in the cycle of the 5th pulse.
- **Run spanning commands:** cmd (0,3) then cmd (0,2) → `RUN_CNT` 1,2,3,4,5; `RUN_HIT` asserts on the 1st bit of the second command.
- **Polarity change:** cmd (1,4) then cmd (0,1) → `RUN_HIT` high after the 4th one, then `RUN_CNT`=1 and `RUN_HIT`=0 on the zero. Also cmd (1,9) → `RUN_CNT` saturates at 7.
- **Zero length and gaps:** cmd (1,0) → no `DOUT_VALID` and `BUSY` stays 0. Cmd (0,3) with `STEP` pattern 1,0,0,1,0,1 → exactly 3 pulses, each aligned to a `STEP` edge, and `DOUT` held between pulses.
- **Mid-run reset:** cmd (1,6), assert `RST` after 2 pulses → outputs cleared, no further pulses. Then cmd (1,2) → `RUN_CNT` 1,2 (no carry-over) and `RUN_HIT` stays 0.
